// File: rtl/i2s_voice_mixer_tx.sv
// i2s_voice_mixer_tx: mixes NUM_VOICES signed PCM voices per channel with
// saturation (or routes them by mode) and serialises left-justified frames.
// Ports:
//   clk, rst          system clock, async active-low reset
//   voice_left/right  packed voice samples, voice k at [k*SAMPLE_W +: SAMPLE_W]
//   voice_en          per-voice enable
//   mode              0 mix, 1 split, 2 mute, 3 mono-left
//   clip_clr          clears the sticky clip flag
//   audio_mclk/sck    master and bit clocks
//   audio_lrck        word select (0 left, 1 right)
//   audio_sdin        serial data, MSB first
//   sample_req        one-clk pulse when the next frame is latched
//   clip              sticky saturation flag
module i2s_voice_mixer_tx #(
    parameter int SAMPLE_W   = 16,
    parameter int NUM_VOICES = 2,
    parameter int BIT_CLKS   = 16,
    parameter int MCLK_DIV   = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_left,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_right,
    input  logic [NUM_VOICES-1:0]          voice_en,
    input  logic [1:0]                     mode,
    input  logic                           clip_clr,
    output logic                           audio_mclk,
    output logic                           audio_sck,
    output logic                           audio_lrck,
    output logic                           audio_sdin,
    output logic                           sample_req,
    output logic                           clip
);

    localparam int FRAME_BITS = 2 * SAMPLE_W;
    localparam int SUM_W      = SAMPLE_W + $clog2(NUM_VOICES);
    localparam int EXT_W      = SUM_W - SAMPLE_W;
    localparam int DIV_W      = $clog2(BIT_CLKS);
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam int MC_W       = $clog2(MCLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BIT_CLKS - 1);
    localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(BIT_CLKS / 2);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_RIGHT = BIT_W'(SAMPLE_W);
    localparam logic [MC_W-1:0]  MC_LAST   = MC_W'(MCLK_DIV - 1);
    localparam logic [MC_W-1:0]  MC_HALF   = MC_W'(MCLK_DIV / 2);

    logic [SUM_W-1:0]      sum_l;
    logic [SUM_W-1:0]      sum_r;
    logic [EXT_W:0]        top_l;
    logic [EXT_W:0]        top_r;
    logic                  ovf_l;
    logic                  ovf_r;
    logic [SAMPLE_W-1:0]   sat_l;
    logic [SAMPLE_W-1:0]   sat_r;
    logic [SAMPLE_W-1:0]   mix_l;
    logic [SAMPLE_W-1:0]   mix_r;
    logic                  mix_clip;

    logic [MC_W-1:0]       mc;
    logic [MC_W-1:0]       mc_nxt;
    logic [DIV_W-1:0]      div;
    logic [DIV_W-1:0]      div_nxt;
    logic [BIT_W-1:0]      bit_idx;
    logic [BIT_W-1:0]      bit_nxt;
    logic [BIT_W-1:0]      sel;
    logic                  div_wrap;
    logic                  latch;
    logic [SAMPLE_W-1:0]   shadow_l;
    logic [SAMPLE_W-1:0]   shadow_r;
    logic [SAMPLE_W-1:0]   shl_nxt;
    logic [SAMPLE_W-1:0]   shr_nxt;
    logic [FRAME_BITS-1:0] frame_nxt;

    always_comb begin
        sum_l = '0;
        sum_r = '0;
        for (int k = 0; k < NUM_VOICES; k++) begin
            if (voice_en[k]) begin
                sum_l = sum_l + {{EXT_W{voice_left[k*SAMPLE_W+SAMPLE_W-1]}},
                                 voice_left[k*SAMPLE_W +: SAMPLE_W]};
                sum_r = sum_r + {{EXT_W{voice_right[k*SAMPLE_W+SAMPLE_W-1]}},
                                 voice_right[k*SAMPLE_W +: SAMPLE_W]};
            end
        end
    end

    // In range iff the guard bits all equal the sample sign bit.
    assign top_l = sum_l[SUM_W-1 -: EXT_W+1];
    assign top_r = sum_r[SUM_W-1 -: EXT_W+1];
    assign ovf_l = !((&top_l) || !(|top_l));
    assign ovf_r = !((&top_r) || !(|top_r));

    assign sat_l = ovf_l ?
        {sum_l[SUM_W-1], {(SAMPLE_W-1){~sum_l[SUM_W-1]}}} :
        sum_l[SAMPLE_W-1:0];
    assign sat_r = ovf_r ?
        {sum_r[SUM_W-1], {(SAMPLE_W-1){~sum_r[SUM_W-1]}}} :
        sum_r[SAMPLE_W-1:0];

    always_comb begin
        mix_l    = '0;
        mix_r    = '0;
        mix_clip = 1'b0;
        unique case (1'b1)
            (mode == 2'd0): begin
                mix_l    = sat_l;
                mix_r    = sat_r;
                mix_clip = ovf_l | ovf_r;
            end
            (mode == 2'd1): begin
                if (voice_en[0]) mix_l = voice_left[SAMPLE_W-1:0];
                if (voice_en[1]) mix_r = voice_right[2*SAMPLE_W-1:SAMPLE_W];
            end
            (mode == 2'd2): begin
                mix_clip = 1'b0;
            end
            default: begin
                mix_l    = sat_l;
                mix_r    = sat_l;
                mix_clip = ovf_l;
            end
        endcase
    end

    assign mc_nxt   = (mc == MC_LAST) ? '0 : mc + 1'b1;
    assign div_wrap = (div == DIV_LAST);
    assign div_nxt  = div_wrap ? '0 : div + 1'b1;
    assign bit_nxt  = !div_wrap ? bit_idx :
                      (bit_idx == BIT_LAST) ? '0 : bit_idx + 1'b1;
    assign latch      = div_wrap && (bit_idx == BIT_LAST);
    assign sample_req = latch;

    // The first bit of a new frame must come from the freshly latched data.
    assign shl_nxt   = latch ? mix_l : shadow_l;
    assign shr_nxt   = latch ? mix_r : shadow_r;
    assign frame_nxt = {shl_nxt, shr_nxt};
    assign sel       = BIT_LAST - bit_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mc         <= '0;
            div        <= '0;
            bit_idx    <= '0;
            shadow_l   <= '0;
            shadow_r   <= '0;
            audio_mclk <= 1'b0;
            audio_sck  <= 1'b0;
            audio_lrck <= 1'b0;
            audio_sdin <= 1'b0;
            clip       <= 1'b0;
        end else begin
            mc         <= mc_nxt;
            div        <= div_nxt;
            bit_idx    <= bit_nxt;
            audio_mclk <= (mc_nxt >= MC_HALF);
            audio_sck  <= (div_nxt >= DIV_HALF);
            if (div_nxt == '0) begin
                audio_sdin <= frame_nxt[sel];
                audio_lrck <= (bit_nxt >= BIT_RIGHT);
            end
            if (latch) begin
                shadow_l <= mix_l;
                shadow_r <= mix_r;
            end
            if (latch && mix_clip) begin
                clip <= 1'b1;
            end else if (clip_clr) begin
                clip <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_voice_mixer_tx.sv
// tb_i2s_voice_mixer_tx: randomized and directed bench for i2s_voice_mixer_tx
// against an arithmetic frame model.
module tb_i2s_voice_mixer_tx;

    localparam int SW    = 16;
    localparam int NV    = 2;
    localparam int BC    = 16;
    localparam int MD    = 4;
    localparam int FRAME = 2 * SW * BC;

    logic             clk = 1'b0;
    logic             rst;
    logic [NV*SW-1:0] voice_left;
    logic [NV*SW-1:0] voice_right;
    logic [NV-1:0]    voice_en;
    logic [1:0]       mode;
    logic             clip_clr;
    logic             audio_mclk;
    logic             audio_sck;
    logic             audio_lrck;
    logic             audio_sdin;
    logic             sample_req;
    logic             clip;

    always #5 clk = ~clk;

    i2s_voice_mixer_tx #(
        .SAMPLE_W  (SW),
        .NUM_VOICES(NV),
        .BIT_CLKS  (BC),
        .MCLK_DIV  (MD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .voice_left (voice_left),
        .voice_right(voice_right),
        .voice_en   (voice_en),
        .mode       (mode),
        .clip_clr   (clip_clr),
        .audio_mclk (audio_mclk),
        .audio_sck  (audio_sck),
        .audio_lrck (audio_lrck),
        .audio_sdin (audio_sdin),
        .sample_req (sample_req),
        .clip       (clip)
    );

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [SW-1:0] exp_l, exp_r, cap_l, cap_r;
    logic        clip_exp, nxt_sat, hold;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic int clampi(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Next-frame words from the inputs present at the latch edge.
    task automatic model_latch();
        int sl, sr;
        logic signed [SW-1:0] t;
        sl = 0;
        sr = 0;
        for (int k = 0; k < NV; k++) begin
            if (voice_en[k]) begin
                t = voice_left[k*SW +: SW];
                sl += int'(t);
                t = voice_right[k*SW +: SW];
                sr += int'(t);
            end
        end
        nxt_sat = 1'b0;
        case (mode)
            2'd0: begin
                exp_l   = SW'(clampi(sl));
                exp_r   = SW'(clampi(sr));
                nxt_sat = (clampi(sl) != sl) || (clampi(sr) != sr);
            end
            2'd1: begin
                exp_l = voice_en[0] ? voice_left[SW-1:0] : '0;
                exp_r = voice_en[1] ? voice_right[2*SW-1:SW] : '0;
            end
            2'd2: begin
                exp_l = '0;
                exp_r = '0;
            end
            default: begin
                exp_l   = SW'(clampi(sl));
                exp_r   = SW'(clampi(sl));
                nxt_sat = (clampi(sl) != sl);
            end
        endcase
    endtask

    task automatic check_cycle();
        int ph, dv, b;
        ph = cyc % FRAME;
        dv = cyc % BC;
        b  = ph / BC;
        chk("mclk", audio_mclk, (cyc % MD) >= MD / 2);
        chk("sck", audio_sck, dv >= BC / 2);
        chk("lrck", audio_lrck, b >= SW);
        chk("sample_req", sample_req, ph == FRAME - 1);
        chk("clip", clip, clip_exp);
        if (dv == 0) hold = audio_sdin;
        else chk("sdin_stable", audio_sdin, hold);
        if (dv == BC / 2) begin
            if (b < SW) cap_l[SW-1-b] = audio_sdin;
            else cap_r[2*SW-1-b] = audio_sdin;
        end
        if (ph == FRAME - 1) begin
            chk("left_word", cap_l, exp_l);
            chk("right_word", cap_r, exp_r);
            model_latch();
        end
    endtask

    task automatic step(input int n);
        logic pre_clr, pre_latch;
        repeat (n) begin
            pre_clr   = clip_clr;
            pre_latch = ((cyc % FRAME) == FRAME - 1);
            @(posedge clk);
            #1;
            cyc++;
            if (pre_latch && nxt_sat) clip_exp = 1'b1;
            else if (pre_clr) clip_exp = 1'b0;
            check_cycle();
        end
    endtask

    task automatic to_latch();
        while ((cyc % FRAME) != FRAME - 1) step(1);
    endtask

    task automatic do_reset(input int hold_cycles);
        #2 rst = 1'b0;
        #1;
        chk("rst_mclk", audio_mclk, 0);
        chk("rst_sck", audio_sck, 0);
        chk("rst_lrck", audio_lrck, 0);
        chk("rst_sdin", audio_sdin, 0);
        chk("rst_sample_req", sample_req, 0);
        chk("rst_clip", clip, 0);
        repeat (hold_cycles) @(posedge clk);
        #2 rst = 1'b1;
        cyc      = 0;
        clip_exp = 1'b0;
        nxt_sat  = 1'b0;
        exp_l    = '0;
        exp_r    = '0;
        cap_l    = '0;
        cap_r    = '0;
        hold     = 1'b0;
        check_cycle();
    endtask

    task automatic rand_inputs();
        voice_left  = $urandom;
        voice_right = $urandom;
        voice_en    = NV'($urandom_range(0, 3));
        mode        = 2'($urandom_range(0, 3));
    endtask

    initial begin
        rst         = 1'b1;
        voice_left  = '0;
        voice_right = '0;
        voice_en    = '0;
        mode        = 2'd0;
        clip_clr    = 1'b0;
        do_reset(3);

        mode        = 2'd0;
        voice_en    = 2'b11;
        voice_left  = {16'h0100, 16'h1234};
        voice_right = {16'h0002, 16'h0001};
        to_latch();
        step(1);

        voice_left  = {16'h2000, 16'h7000};
        voice_right = {16'hFFFF, 16'h8000};
        to_latch();
        step(1);
        step(100);
        clip_clr = 1'b1;
        step(1);
        clip_clr = 1'b0;
        to_latch();
        clip_clr = 1'b1;
        step(1);
        clip_clr = 1'b0;

        mode        = 2'd1;
        voice_en    = 2'b01;
        voice_left  = {16'h1111, 16'hAAAA};
        voice_right = {16'h5555, 16'h2222};
        to_latch();
        step(1);
        mode = 2'd2;
        to_latch();
        step(1);

        mode        = 2'd1;
        voice_en    = 2'b11;
        voice_left  = {16'h0100, 16'h1234};
        voice_right = {16'h0002, 16'h0001};
        to_latch();
        step(1);
        step(5 * BC);
        mode = 2'd0;
        to_latch();
        step(1);
        mode        = 2'd3;
        voice_left  = {16'h9000, 16'h9000};
        to_latch();
        step(1);

        for (int f = 0; f < 10; f++) begin
            rand_inputs();
            step($urandom_range(0, 300));
            rand_inputs();
            if ($urandom_range(0, 3) == 0) begin
                clip_clr = 1'b1;
                step(1);
                clip_clr = 1'b0;
            end
            to_latch();
            if ($urandom_range(0, 2) == 0) clip_clr = 1'b1;
            step(1);
            clip_clr = 1'b0;
        end

        mode        = 2'd0;
        voice_en    = 2'b11;
        voice_left  = {16'hFFFF, 16'hFFFF};
        voice_right = {16'h7FFF, 16'h7FFF};
        to_latch();
        step(1);
        step(20 * BC + 3);
        do_reset(4);
        to_latch();
        step(1);
        to_latch();
        step(1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/i2s_voice_mixer_tx.md
Name: i2s_voice_mixer_tx

Overview:
- Parametrised next-generation audio output stage for the keyboard-piano designs.
- Takes NUM_VOICES signed PCM voices per channel from note generators and mixes the enabled voices with saturation, or routes them according to a mode.
- Generates MCLK/SCK/LRCK from the system clock and serialises left-justified 16-bit-style frames to the DAC.
- Replaces the ad-hoc per-design bit-mux serialiser with a single reusable block.

Parameters:
- SAMPLE_W, 16, bits per channel sample (signed two's complement).
- NUM_VOICES, 2, number of voice inputs per channel (>=2).
- BIT_CLKS, 16, clk cycles per SCK period (even, >=4).
- MCLK_DIV, 4, clk cycles per MCLK period (even, >=2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- voice_left  in  NUM_VOICES*SAMPLE_W  left samples; voice k occupies [k*SAMPLE_W +: SAMPLE_W].
- voice_right  in  NUM_VOICES*SAMPLE_W  right samples, same packing.
- voice_en  in  NUM_VOICES  per-voice enable; disabled voice contributes 0.
- mode  in  2  0=mix, 1=split, 2=mute, 3=mono-left.
- clip_clr  in  1  clears clip flag.
- audio_mclk  out  1  master clock.
- audio_sck  out  1  bit clock.
- audio_lrck  out  1  word select; 0=left, 1=right.
- audio_sdin  out  1  serial data.
- sample_req  out  1  one-clk pulse when the frame is latched.
- clip  out  1  sticky saturation flag.

Behaviour:
- Reset (rst=0, async): all counters 0, shadow registers 0, all outputs 0. Reset mid-frame aborts the frame immediately. After release, the first frame starts at div=0, bit=0 with latched data.
- MCLK: free counter 0..MCLK_DIV-1. audio_mclk is registered, high for the upper half of the count.
- Bit timing: div counts 0..BIT_CLKS-1 and wraps; bit index counts 0..2*SAMPLE_W-1, advancing when div wraps.
- audio_sck is registered: 0 for div < BIT_CLKS/2, 1 otherwise. DAC samples on the SCK rising edge.
- audio_lrck = (bit >= SAMPLE_W), registered, changes on the same clk as sdin.
- Frame period is 2*SAMPLE_W*BIT_CLKS clk.
- Serialisation: left-justified, no 1-bit delay. MSB is driven in the same cycle as the LRCK edge.
- audio_sdin is updated only at div=0 (SCK falling). It carries shadow_L[SAMPLE_W-1-bit] for bit<SAMPLE_W, else shadow_R[2*SAMPLE_W-1-bit].
- Latch: in the clk where div=BIT_CLKS-1 and bit=2*SAMPLE_W-1 (last edge of the frame), shadow_L/shadow_R capture the mixer outputs and sample_req pulses high for exactly that cycle.
- Upstream may change inputs after the pulse; the inputs are sampled only at the latch.
- Mixer (combinational, sampled only at latch):
  - mode 0: L = sat(sum of enabled voice_left[k]); R likewise from voice_right.
  - mode 1: L = voice 0 left if en[0] else 0; R = voice 1 right if en[1] else 0. No sum, never clips.
  - mode 2: L=R=0.
  - mode 3: L=R=sat(sum of enabled voice_left[k]).
  - Sum width is SAMPLE_W+clog2(NUM_VOICES) signed. sat() clamps to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].
- Clip: set at the latch when either channel saturated. Held until clip_clr=1 at a clk edge.
  - clip_clr and a new saturation in the same cycle: clip=1 (set wins).
- Mode/voice_en changes mid-frame take effect only at the next latch; the current frame is untouched.
- The first frame after reset carries zeros (shadow reset value); the first sample_req occurs at clk 2*SAMPLE_W*BIT_CLKS-1 after release.

Test Plan:
- Defaults, reset release → MCLK period 4 clk, SCK period 16 clk, LRCK period 512 clk, LRCK toggles every 256 clk; sample_req pulses once per 512 clk, first at cycle 511.
- mode 0, voice0 L=0x1234, voice1 L=0x0100, R=0x0001/0x0002, en=2'b11 → next frame left word 0x1334, right word 0x0003, MSB first, sdin stable across each SCK rising edge; clip=0.
- mode 0, L 0x7000+0x2000 and R 0x8000+0xFFFF → left 0x7FFF, right 0x8000, clip=1. Stays 1 until clip_clr pulse. clip_clr together with another saturating latch → clip stays 1.
- mode 1, voice0 L=0xAAAA, voice1 R=0x5555, en=2'b01 → left 0xAAAA, right 0x0000. mode 2 → both words 0x0000.
- Change mode from 1 to 0 at bit 5 of a frame → current frame keeps split data, next frame mixed.
- Assert rst low at bit 20 → all outputs 0 within the same clk (async). After release, timing restarts at bit 0 and the first frame is zeros.
